// File: rtl/mapper_ext.sv
// Memory mapper: 7FFD/DFFD paging registers, slot decode to ROM/SRAM, and SRAM write-strobe sequencing.
// Define MAPPER_PLUS3_EN to build the 1FFD register with its all-RAM maps and ROM bank bit 1.
module mapper_ext #(
    parameter int unsigned RAM_PAGE_BITS = 3,
    parameter int unsigned ROM_BANK_BITS = 2,
    parameter int unsigned RAM_ADDR_W    = 19,
    parameter int unsigned WE_CYCLES     = 2
) (
    input  logic                      clk,
    input  logic                      mrst_n,
    input  logic                      cpurst_n,
    input  logic [15:0]               a,
    input  logic                      mreq_n,
    input  logic                      iorq_n,
    input  logic                      rd_n,
    input  logic                      wr_n,
    input  logic [7:0]                din,
    output logic                      vrampage,
    output logic [ROM_BANK_BITS+13:0] addr_rom,
    output logic                      oe_n_rom,
    output logic [RAM_ADDR_W-1:0]     addr_ram,
    output logic                      oe_n_ram,
    output logic                      we_n_ram
);
    localparam int unsigned DFFD_W  = RAM_PAGE_BITS - 3;
    localparam int unsigned DFFD_WS = (DFFD_W > 0) ? DFFD_W : 1;

    typedef enum logic [1:0] {IDLE, SETUP, WRITE, HOLD} wr_state_e;

    logic [5:0]               bank128_q, bank128_d;
    logic [DFFD_WS-1:0]       dffd_q, dffd_d;
    logic [2:0]               bankplus3;
    logic                     iow, iow_d_q, load;
    logic                     sel_7ffd, sel_dffd;
    logic [RAM_PAGE_BITS-1:0] c000_page, page;
    logic [ROM_BANK_BITS-1:0] rom_bank;
    logic [2:0]               allram_page;
    logic                     all_ram, ram_sel, wstrobe;
    wr_state_e                state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     unused_din;

    assign unused_din = ^din[7:6];

    // One load per I/O cycle: only the rising edge of iow counts, and the lock bit blocks everything.
    assign iow      = !iorq_n && !wr_n;
    assign load     = iow && !iow_d_q && !bank128_q[5];
    assign sel_7ffd = (a[1:0] == 2'b01) && a[14] && !a[15];
    assign sel_dffd = (a[1:0] == 2'b01) && (a[15:12] == 4'hD);

    always_comb begin
        bank128_d = bank128_q;
        dffd_d    = dffd_q;
        if (load && sel_7ffd) begin
            bank128_d = din[5:0];
        end
        if (load && sel_dffd && (DFFD_W > 0)) begin
            dffd_d = din[DFFD_WS-1:0];
        end
    end

`ifdef MAPPER_PLUS3_EN
    logic       sel_1ffd;
    logic [2:0] bankplus3_q, bankplus3_d;

    assign sel_1ffd = (a[1:0] == 2'b01) && a[12] && (a[15:13] == 3'b000);

    always_comb begin
        bankplus3_d = bankplus3_q;
        if (load && sel_1ffd) begin
            bankplus3_d = din[2:0];
        end
    end

    always_ff @(posedge clk or negedge mrst_n) begin
        if (!mrst_n) begin
            bankplus3_q <= '0;
        end else if (!cpurst_n) begin
            bankplus3_q <= '0;
        end else begin
            bankplus3_q <= bankplus3_d;
        end
    end

    assign bankplus3 = bankplus3_q;
`else
    assign bankplus3 = '0;
`endif

    assign vrampage = bank128_q[3];
    assign all_ram  = bankplus3[0];
    // With DFFD absent the single unused bit falls off the top in this truncating cast.
    assign c000_page = RAM_PAGE_BITS'({dffd_q, bank128_q[2:0]});
    assign rom_bank  = ROM_BANK_BITS'({bankplus3[2], bank128_q[4]});

    always_comb begin
        allram_page = 3'd0;
        unique case (bankplus3[2:1])
            2'b00: allram_page = {1'b0, a[15:14]};
            2'b01: allram_page = {1'b1, a[15:14]};
            2'b10: allram_page = (a[15:14] == 2'b11) ? 3'd3 : {1'b1, a[15:14]};
            2'b11: begin
                unique case (a[15:14])
                    2'b00: allram_page = 3'd4;
                    2'b01: allram_page = 3'd7;
                    2'b10: allram_page = 3'd6;
                    2'b11: allram_page = 3'd3;
                    default: allram_page = 3'd0;
                endcase
            end
            default: allram_page = 3'd0;
        endcase
    end

    always_comb begin
        oe_n_rom = 1'b1;
        oe_n_ram = 1'b1;
        addr_rom = '0;
        addr_ram = '0;
        ram_sel  = 1'b0;
        page     = '0;
        if (!mreq_n) begin
            if (all_ram) begin
                ram_sel = 1'b1;
                page    = RAM_PAGE_BITS'(allram_page);
            end else begin
                unique case (a[15:14])
                    2'b00: begin
                        oe_n_rom = 1'b0;
                        addr_rom = {rom_bank, a[13:0]};
                    end
                    2'b01: begin
                        ram_sel = 1'b1;
                        page    = RAM_PAGE_BITS'(3'd5);
                    end
                    2'b10: begin
                        ram_sel = 1'b1;
                        page    = RAM_PAGE_BITS'(3'd2);
                    end
                    2'b11: begin
                        ram_sel = 1'b1;
                        page    = c000_page;
                    end
                    default: ram_sel = 1'b0;
                endcase
            end
            if (ram_sel) begin
                addr_ram = RAM_ADDR_W'({page, a[13:0]});
                oe_n_ram = rd_n;
            end
        end
    end

    assign wstrobe = !mreq_n && !wr_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!wstrobe) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ram_sel) begin
                        state_d = SETUP;
                        cnt_d   = '0;
                    end
                end
                SETUP: begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end
                WRITE: begin
                    if (cnt_q == 4'(WE_CYCLES - 1)) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                HOLD: begin
                    state_d = HOLD;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Gating with the live strobe ends the pulse in the same cycle the CPU lets go.
    assign we_n_ram = !((state_q == WRITE) && wstrobe);

    always_ff @(posedge clk or negedge mrst_n) begin
        if (!mrst_n) begin
            bank128_q <= '0;
            dffd_q    <= '0;
            iow_d_q   <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
        end else if (!cpurst_n) begin
            bank128_q <= '0;
            dffd_q    <= '0;
            iow_d_q   <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
        end else begin
            bank128_q <= bank128_d;
            dffd_q    <= dffd_d;
            iow_d_q   <= iow;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mapper_ext.sv
// Bench for mapper_ext: directed paging/strobe scenarios plus randomized bus traffic against a behavioural model.
module tb_mapper_ext;
    localparam int unsigned RPB = 5;
    localparam int unsigned RBB = 2;
    localparam int unsigned RAW = 19;
    localparam int unsigned WEC = 3;
    localparam int unsigned DMASK = (1 << (RPB - 3)) - 1;
`ifdef MAPPER_PLUS3_EN
    localparam bit PLUS3 = 1'b1;
`else
    localparam bit PLUS3 = 1'b0;
`endif

    logic clk = 1'b0;
    logic mrst_n, cpurst_n, mreq_n, iorq_n, rd_n, wr_n;
    logic [15:0] a;
    logic [7:0] din;
    logic vrampage, oe_n_rom, oe_n_ram, we_n_ram;
    logic [RBB+13:0] addr_rom;
    logic [RAW-1:0] addr_ram;

    int checks = 0;
    int errors = 0;

    logic [7:0] m7, m1, md;
    bit iow_prev;
    int unsigned wcnt;
    logic [31:0] e_vr, e_arom, e_oerom, e_aram, e_oeram, e_we;
    int unsigned ar_tab [4][4] = '{'{0, 1, 2, 3}, '{4, 5, 6, 7}, '{4, 5, 6, 3}, '{4, 7, 6, 3}};

    mapper_ext #(
        .RAM_PAGE_BITS(RPB),
        .ROM_BANK_BITS(RBB),
        .RAM_ADDR_W(RAW),
        .WE_CYCLES(WEC)
    ) dut (
        .clk(clk), .mrst_n(mrst_n), .cpurst_n(cpurst_n), .a(a),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .din(din),
        .vrampage(vrampage), .addr_rom(addr_rom), .oe_n_rom(oe_n_rom),
        .addr_ram(addr_ram), .oe_n_ram(oe_n_ram), .we_n_ram(we_n_ram)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m7 = '0; m1 = '0; md = '0; iow_prev = 1'b0; wcnt = 0;
    endtask

    function automatic bit model_ram_sel();
        if (mreq_n) return 1'b0;
        if (PLUS3 && m1[0]) return 1'b1;
        return a[15:14] != 2'b00;
    endfunction

    task automatic calc_expect();
        int unsigned slot, page, rombank, off;
        slot = 32'(a[15:14]);
        off  = 32'(a[13:0]);
        page = 0;
        e_vr = 32'(m7[3]); e_arom = '0; e_oerom = 1; e_aram = '0; e_oeram = 1;
        e_we = 32'(!(wcnt >= 2 && wcnt <= 1 + WEC && !mreq_n && !wr_n));
        if (!mreq_n) begin
            if (model_ram_sel()) begin
                if (PLUS3 && m1[0]) page = ar_tab[32'(m1[2:1])][slot];
                else if (slot == 1) page = 5;
                else if (slot == 2) page = 2;
                else page = 32'(md) * 8 + 32'(m7[2:0]);
                e_aram  = page * 16384 + off;
                e_oeram = 32'(rd_n);
            end else begin
                rombank = 32'(m7[4]);
                if (PLUS3) rombank += 2 * 32'(m1[2]);
                e_arom  = rombank * 16384 + off;
                e_oerom = 0;
            end
        end
    endtask

    // Register and strobe-timing effects of one rising clock edge, using the inputs present at that edge.
    task automatic model_edge();
        bit strobe, iow;
        if (!mrst_n || !cpurst_n) begin
            reset_model();
            return;
        end
        strobe = !mreq_n && !wr_n;
        if (!strobe) wcnt = 0;
        else if (wcnt == 0) begin
            if (model_ram_sel()) wcnt = 1;
        end else if (wcnt < 1000) wcnt++;
        iow = !iorq_n && !wr_n;
        if (iow && !iow_prev && !m7[5] && a[1:0] == 2'b01) begin
            if (!a[15] && a[14]) m7 = din;
            else if (a[15:13] == 3'b000 && a[12]) begin
                if (PLUS3) m1 = din;
            end else if (a[15:12] == 4'hD) md = din & 8'(DMASK);
        end
        iow_prev = iow;
    endtask

    task automatic probe();
        @(negedge clk);
        calc_expect();
        chk("vrampage", 32'(vrampage), e_vr);
        chk("addr_rom", 32'(addr_rom), e_arom);
        chk("oe_n_rom", 32'(oe_n_rom), e_oerom);
        chk("addr_ram", 32'(addr_ram), e_aram);
        chk("oe_n_ram", 32'(oe_n_ram), e_oeram);
        chk("we_n_ram", 32'(we_n_ram), e_we);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cyc();
        probe();
        tick();
    endtask

    task automatic idle();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic io_out(input logic [15:0] port, input logic [7:0] d);
        a = port; din = d; iorq_n = 1'b0; wr_n = 1'b0;
        cyc(); cyc();
        idle(); cyc();
    endtask

    task automatic begin_rd(input logic [15:0] ad);
        a = ad; mreq_n = 1'b0; rd_n = 1'b0;
        probe();
    endtask

    task automatic end_op();
        tick(); idle(); cyc();
    endtask

    task automatic cpurst_pulse();
        cpurst_n = 1'b0; cyc();
        cpurst_n = 1'b1; cyc();
    endtask

    initial begin
        int unsigned kind, len;
        mrst_n = 1'b0; cpurst_n = 1'b1; a = '0; din = '0;
        idle(); reset_model();
        probe();
        chk("rst_vrampage", 32'(vrampage), 0);
        chk("rst_addr_rom", 32'(addr_rom), 0);
        chk("rst_oe_n_rom", 32'(oe_n_rom), 1);
        chk("rst_addr_ram", 32'(addr_ram), 0);
        chk("rst_oe_n_ram", 32'(oe_n_ram), 1);
        chk("rst_we_n_ram", 32'(we_n_ram), 1);
        tick(); mrst_n = 1'b1; cyc();

        io_out(16'h7FFD, 8'h17);
        begin_rd(16'hC123);
        chk("p7_addr_ram", 32'(addr_ram), 32'h1C123);
        chk("p7_oe_n_ram", 32'(oe_n_ram), 0);
        chk("p7_vrampage", 32'(vrampage), 0);
        end_op();
        begin_rd(16'h0123);
        chk("rom1_addr_rom", 32'(addr_rom), 32'h4123);
        chk("rom1_oe_n_rom", 32'(oe_n_rom), 0);
        end_op();

        // Held I/O write with data changing mid-cycle.
        a = 16'h7FFD; din = 8'h01; iorq_n = 1'b0; wr_n = 1'b0;
        cyc(); cyc();
        din = 8'h03;
        cyc(); cyc(); cyc();
        idle(); cyc();
        begin_rd(16'hC000);
        chk("onceload_addr_ram", 32'(addr_ram), 32'h04000);
        end_op();

        io_out(16'h7FFD, 8'h20);
        io_out(16'h7FFD, 8'h07);
        io_out(16'hDFFD, 8'h03);
        begin_rd(16'hC010);
        chk("lock_addr_ram", 32'(addr_ram), 32'h00010);
        end_op();
        cpurst_pulse();
        io_out(16'h7FFD, 8'h07);
        begin_rd(16'hC010);
        chk("unlock_addr_ram", 32'(addr_ram), 32'h1C010);
        end_op();

        cpurst_pulse();
        io_out(16'hDFFD, 8'h03);
        io_out(16'h7FFD, 8'h05);
        begin_rd(16'hC001);
        chk("dffd_addr_ram", 32'(addr_ram), 32'h74001);
        end_op();

        cpurst_pulse();
        a = 16'h8000; din = 8'hAA; mreq_n = 1'b0; wr_n = 1'b0;
        for (int k = 0; k < 8; k++) begin
            probe();
            chk("wlong_we_n", 32'(we_n_ram), 32'((k >= 2 && k <= 4) ? 0 : 1));
            tick();
        end
        idle(); cyc();
        a = 16'h8004; mreq_n = 1'b0; wr_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mreq_n = 1'b1;
            probe();
            chk("wcut_we_n", 32'(we_n_ram), 32'((k == 2) ? 0 : 1));
            tick();
        end
        idle(); cyc();

        a = 16'h0100; mreq_n = 1'b0; wr_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            probe();
            chk("romwr_we_n", 32'(we_n_ram), 1);
            tick();
        end
        idle(); cyc();

        a = 16'h4000; mreq_n = 1'b0; wr_n = 1'b0;
        cyc(); cyc(); probe();
        chk("mrst_pre_we_n", 32'(we_n_ram), 0);
        mrst_n = 1'b0; reset_model(); #1;
        chk("mrst_async_we_n", 32'(we_n_ram), 1);
        idle(); tick(); mrst_n = 1'b1; cyc();

        a = 16'h4000; mreq_n = 1'b0; wr_n = 1'b0;
        cyc(); cyc(); probe();
        cpurst_n = 1'b0; #1;
        chk("cprst_hold_we_n", 32'(we_n_ram), 0);
        tick(); probe();
        chk("cprst_rel_we_n", 32'(we_n_ram), 1);
        cpurst_n = 1'b1; idle(); tick(); cyc();

        io_out(16'h1FFD, 8'h07);
        begin_rd(16'h0005);
        chk("p3_s0_addr_ram", 32'(addr_ram), PLUS3 ? 32'h10005 : 32'h0);
        chk("p3_s0_oe_n_rom", 32'(oe_n_rom), PLUS3 ? 32'h1 : 32'h0);
        end_op();
        begin_rd(16'h4005);
        chk("p3_s1_addr_ram", 32'(addr_ram), PLUS3 ? 32'h1C005 : 32'h14005);
        end_op();
        begin_rd(16'h8005);
        chk("p3_s2_addr_ram", 32'(addr_ram), PLUS3 ? 32'h18005 : 32'h08005);
        end_op();
        begin_rd(16'hC005);
        chk("p3_s3_addr_ram", 32'(addr_ram), PLUS3 ? 32'h0C005 : 32'h00005);
        end_op();
        a = 16'h0200; mreq_n = 1'b0; wr_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            probe();
            chk("p3_romwr_we_n", 32'(we_n_ram), 32'((PLUS3 && k >= 2 && k <= 4) ? 0 : 1));
            tick();
        end
        idle(); cyc();
        cpurst_pulse();
        io_out(16'h1FFD, 8'h04);
        io_out(16'h7FFD, 8'h10);
        begin_rd(16'h0033);
        chk("rombank_addr_rom", 32'(addr_rom), PLUS3 ? 32'hC033 : 32'h4033);
        end_op();

        cpurst_pulse();
        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 3);
            len  = $urandom_range(1, 6);
            if ($urandom_range(0, 19) == 0) cpurst_n = 1'b0;
            a   = 16'($urandom());
            din = 8'($urandom());
            if ($urandom_range(0, 3) != 0) din[5] = 1'b0;
            case (kind)
                1: begin mreq_n = 1'b0; rd_n = 1'b0; end
                2: begin mreq_n = 1'b0; wr_n = 1'b0; end
                3: begin
                    case ($urandom_range(0, 3))
                        0: a = 16'h7FFD;
                        1: a = 16'h1FFD;
                        2: a = 16'hDFFD;
                        default: a = a;
                    endcase
                    iorq_n = 1'b0; wr_n = 1'b0;
                end
                default: idle();
            endcase
            for (int c = 0; c < int'(len); c++) cyc();
            cpurst_n = 1'b1;
            idle(); cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
